// File: rtl/aes_pipe_pkg.sv
// rtl/aes_pipe_pkg.sv - shared constants for the AES round pipeline
// Holds the final-round Rcon values per key size and the default
// state/tag widths used by the capture stage.
package aes_pipe_pkg;

  localparam logic [7:0] AES_RCON_FINAL_128 = 8'h36;
  localparam logic [7:0] AES_RCON_FINAL_192 = 8'h80;
  localparam logic [7:0] AES_RCON_FINAL_256 = 8'h40;

  localparam int AES_DATA_W = 128;
  localparam int AES_TAG_W  = 8;

endpackage

// File: rtl/aes_capture_fifo.sv
// rtl/aes_capture_fifo.sv - generic DEPTH x WIDTH show-ahead FIFO
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   push, wr_data    : write strobe and data (caller guarantees room or a same-cycle pop)
//   pop              : read strobe (caller guarantees valid)
//   rd_data          : head entry, presented combinationally from memory
//   valid, full      : registered occupancy flags
//   level            : registered occupancy, 0..DEPTH
module aes_capture_fifo #(
  parameter int WIDTH = 136,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_next;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + (ADDR_W+1)'(1);
      2'b01:   level_next = level - (ADDR_W+1)'(1);
      default: level_next = level;
    endcase
  end

  // Memory is reset so that the head reads as zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level_next;
      valid <= (level_next != '0);
      full  <= (level_next == (ADDR_W+1)'(DEPTH));
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/aes_final_capture.sv
// rtl/aes_final_capture.sv - final-round capture stage feeding a show-ahead FIFO
// Optional macro AES_CAPTURE_STATS_EN adds saturating cap_count/drop_count outputs.
// Ports:
//   clock, reset_n                    : clock, asynchronous active-low reset
//   in_valid/in_rcon/in_tag/in_data   : round pipeline tail
//   out_valid/out_ready/out_data/out_tag : drain handshake, head entry
//   level, full                       : FIFO occupancy
//   overflow, ovf_clear               : sticky drop flag and its clear
//   cap_count, drop_count             : statistics (macro only)
module aes_final_capture
  import aes_pipe_pkg::*;
#(
  parameter int         DATA_W     = AES_DATA_W,
  parameter int         TAG_W      = AES_TAG_W,
  parameter int         DEPTH      = 4,
  parameter logic [7:0] FINAL_RCON = AES_RCON_FINAL_128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_rcon,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  input  logic                   ovf_clear,
  output logic                   overflow
`ifdef AES_CAPTURE_STATS_EN
  ,
  output logic [15:0]            cap_count,
  output logic [15:0]            drop_count
`endif
);

  logic cap;
  logic pop;
  logic push;
  logic drop;
  logic [TAG_W+DATA_W-1:0] head;

  assign cap  = in_valid && (in_rcon == FINAL_RCON);
  assign pop  = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  aes_capture_fifo #(
    .WIDTH (TAG_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wr_data ({in_tag, in_data}),
    .pop     (pop),
    .rd_data (head),
    .valid   (out_valid),
    .full    (full),
    .level   (level)
  );

  assign out_data = head[DATA_W-1:0];
  assign out_tag  = head[TAG_W+DATA_W-1:DATA_W];

  // Set has priority over clear so a drop is never hidden by a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef AES_CAPTURE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push && (cap_count != 16'hFFFF))  cap_count  <= cap_count + 16'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/aes_final_capture.md
# aes_final_capture

Parametrised output capture stage at the tail of the AES round pipeline. Each cycle it samples the last round's state together with its round constant. When the constant equals the configured final-round value, it pushes the state and a block tag into a small show-ahead FIFO. The FIFO drains through a valid/ready handshake, so a stalled consumer no longer loses ciphertext silently. Overflow is reported explicitly.

## Interface
Parameters:
- DATA_W, 128: state width in bits; must be a multiple of 8. Byte i is in_data[8*i+7:8*i].
- TAG_W, 8: width of the per-block tag carried alongside the data.
- DEPTH, 4: FIFO entries; must be a power of two, ≥ 2. ADDR_W = $clog2(DEPTH).
- FINAL_RCON, 8'h36: Rcon value that marks the final round. Use 8'h36 for AES-128, 8'h80 for AES-192, 8'h40 for AES-256.

Ports:
- clock, input, 1: the single clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_rcon/in_tag/in_data are meaningful this cycle.
- in_rcon, input, 8: round constant of the presented state.
- in_tag, input, TAG_W: block identifier, carried through unchanged.
- in_data, input, DATA_W: round output state.
- out_valid, output, 1: FIFO non-empty; out_data/out_tag hold the head entry.
- out_ready, input, 1: consumer accepts the head entry this cycle.
- out_data, output, DATA_W: head entry data.
- out_tag, output, TAG_W: head entry tag.
- level, output, ADDR_W+1: current occupancy, 0..DEPTH.
- full, output, 1: level == DEPTH.
- overflow, output, 1: sticky flag; a final-round block was dropped.
- ovf_clear, input, 1: clears overflow.

## Operation
- Capture condition: cap = in_valid && (in_rcon == FINAL_RCON). No effect when cap = 0, regardless of the other inputs.
- Pop: pop = out_valid && out_ready.
- Push: push = cap && (!full || pop).
  - When full, a simultaneous pop frees the slot, so the push is accepted.
- Drop: drop = cap && full && !pop.
  - On drop, overflow is set and the FIFO contents are unchanged.
- Overflow clear: ovf_clear clears overflow. If a drop occurs in the same cycle, set wins.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH. level increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Show-ahead output: out_data/out_tag = mem[rd_ptr]. Values are only meaningful while out_valid = 1.
- out_valid = (level != 0), registered. full = (level == DEPTH), registered.
- Asserting reset_n low mid-operation immediately discards all entries.

## Timing
- Reset values: out_valid 0, level 0, full 0, overflow 0, out_data 0, out_tag 0, all memory entries 0. With the Configuration macro enabled, cap_count 0 and drop_count 0.
- Latency: a push at edge N makes out_valid = 1 and presents the data after edge N (one cycle). A pop at edge N presents the next entry after edge N.
- Throughput: one push and one pop per cycle, sustained.
- Handshake: while out_valid = 1 and out_ready = 0, out_data/out_tag stay stable. out_valid never deasserts without a pop.

## Configuration
- AES_CAPTURE_STATS_EN defined adds two outputs, cap_count[15:0] and drop_count[15:0]:
  - cap_count increments on push.
  - drop_count increments on drop.
  - Both saturate at 16'hFFFF, are cleared by reset only, and are unaffected by ovf_clear.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package aes_pipe_pkg holds:
  - AES_RCON_FINAL_128 (8'h36), AES_RCON_FINAL_192 (8'h80), AES_RCON_FINAL_256 (8'h40);
  - the default DATA_W/TAG_W constants.
- Sub-module aes_capture_fifo: a generic DEPTH × (DATA_W+TAG_W) show-ahead FIFO with push/pop/level/full.
- The top level owns capture qualification, overflow and stats.

## Test plan
- Reset, then in_valid=1, in_rcon=8'h36, in_tag=8'h05, in_data=128'h3925841d02dc09fbdc118597196a0b32 -> next cycle out_valid=1, out_data and out_tag match, level=1.
- in_valid=1 with in_rcon=8'h1b, or in_valid=0 with in_rcon=8'h36 -> no push, level stays 0.
- out_ready=0, push 4 blocks (tags 1-4), then a 5th (tag 5) -> full=1, overflow=1, drain order 1,2,3,4, tag 5 never appears.
- Full FIFO, push tag 9 in the same cycle as a pop with out_ready=1 -> no overflow, level stays 4, tag 9 emerges last.
- Overflow set, ovf_clear=1 in the same cycle as another drop -> overflow stays 1. ovf_clear alone next cycle -> overflow=0.
- FINAL_RCON=8'h40 instance: 8'h36 blocks are ignored and 8'h40 blocks are captured. Reset_n pulsed low mid-stream -> all outputs return to reset values asynchronously.
